// File: rtl/dbg_dispatch_pkg.sv
// dbg_dispatch_pkg
// Shared definitions for the JTAG debug command dispatcher: the FSM state
// encoding and the default values of the dispatcher parameters.
package dbg_dispatch_pkg;

    localparam int DEF_DATA_W  = 38;
    localparam int DEF_IR_W    = 2;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/dbg_toggle_sync.sv
// dbg_toggle_sync
// Brings an asynchronous toggle line into the clk domain and turns each change
// of level into a single-cycle event.
//
// Ports:
//   clk      - system clock
//   reset_n  - synchronous active-low reset
//   tgl      - asynchronous toggle input (each level change is one event)
//   evt      - single-cycle event, high when the last two stages differ
module dbg_toggle_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic tgl,
    output logic evt
);

    logic       sync1;
    logic       sync2;
    logic       edge_q;
    logic [1:0] arm_cnt;
    logic       armed;

    // After reset the stages are all 0 while the toggle line may already sit
    // at 1. The edge flop keeps reloading from the synchroniser and events
    // stay masked until the pipeline has been refilled from the live input,
    // so a toggle that was already high is not mistaken for a change.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            edge_q  <= 1'b0;
            arm_cnt <= 2'd0;
        end else begin
            sync1  <= tgl;
            sync2  <= sync1;
            edge_q <= sync2;
            if (arm_cnt != 2'd3) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    assign armed = (arm_cnt == 2'd3);
    assign evt   = armed & (sync2 ^ edge_q);

endmodule

// File: rtl/debug_cmd_dispatch.sv
// debug_cmd_dispatch
// Captures a JTAG data-register snapshot on every update-DR toggle, holds it
// until the addressed channel is ready, then issues a one-cycle action or
// no-action strobe to that channel. The MSB of the captured word selects
// action (1) or no-action (0); the instruction register selects the channel.
//
// Optional feature: define DBG_DISPATCH_TIMEOUT_EN to bound the time a command
// may stay pending to TIMEOUT cycles; otherwise the wait is unbounded and
// timeout is tied to 0.
//
// Ports:
//   clk            - system clock
//   reset_n        - synchronous active-low reset
//   sr             - shift-register snapshot (stable while udr_tgl settles)
//   ir_in          - instruction / channel select (stable with sr)
//   udr_tgl        - asynchronous update-DR toggle
//   uir_tgl        - asynchronous update-IR toggle
//   ch_ready       - per-channel ready to accept a strobe
//   clr_status     - clears the sticky overrun/timeout flags
//   jdo            - captured command word
//   take_action    - one-hot single-cycle action strobe
//   take_no_action - one-hot single-cycle no-action strobe
//   cmd_pending    - a command is waiting for its channel
//   overrun        - sticky: an update-DR arrived while a command was pending
//   timeout        - sticky: a pending command was abandoned
module debug_cmd_dispatch
    import dbg_dispatch_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int IR_W    = DEF_IR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DATA_W-1:0]    sr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic                 udr_tgl,
    input  logic                 uir_tgl,
    input  logic [2**IR_W-1:0]   ch_ready,
    input  logic                 clr_status,
    output logic [DATA_W-1:0]    jdo,
    output logic [2**IR_W-1:0]   take_action,
    output logic [2**IR_W-1:0]   take_no_action,
    output logic                 cmd_pending,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int NUM_CH = 2**IR_W;

    state_t              state;
    state_t              state_nxt;
    logic [IR_W-1:0]     ch;
    logic [IR_W-1:0]     ch_nxt;
    logic [DATA_W-1:0]   jdo_nxt;
    logic [NUM_CH-1:0]   act_nxt;
    logic [NUM_CH-1:0]   noact_nxt;
    logic [NUM_CH-1:0]   ch_onehot;
    logic                capture;
    logic                set_ovr;
    logic                udr_evt;
    logic                uir_evt;
`ifdef DBG_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    wait_cnt;
    logic                set_to;
`endif

    dbg_toggle_sync u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl     (udr_tgl),
        .evt     (udr_evt)
    );

    dbg_toggle_sync u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl     (uir_tgl),
        .evt     (uir_evt)
    );

    assign ch_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << ch;

    always_comb begin
        state_nxt = state;
        ch_nxt    = ch;
        jdo_nxt   = jdo;
        act_nxt   = '0;
        noact_nxt = '0;
        capture   = 1'b0;
        set_ovr   = 1'b0;
`ifdef DBG_DISPATCH_TIMEOUT_EN
        set_to    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (udr_evt) begin
                    capture = 1'b1;
                end
            end
            WAIT: begin
                if (uir_evt) begin
                    // Abort; a simultaneous update-DR starts the new command.
                    state_nxt = IDLE;
                    capture   = udr_evt;
                end else begin
                    set_ovr = udr_evt;
                    if (ch_ready[ch]) begin
                        state_nxt = IDLE;
                        if (jdo[DATA_W-1]) begin
                            act_nxt = ch_onehot;
                        end else begin
                            noact_nxt = ch_onehot;
                        end
                    end
`ifdef DBG_DISPATCH_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state_nxt = IDLE;
                        set_to    = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (capture) begin
            state_nxt = WAIT;
            ch_nxt    = ir_in;
            jdo_nxt   = sr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            ch             <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
        end else begin
            state          <= state_nxt;
            ch             <= ch_nxt;
            jdo            <= jdo_nxt;
            take_action    <= act_nxt;
            take_no_action <= noact_nxt;
            // A new overrun in the same cycle as a clear is kept.
            if (set_ovr) begin
                overrun <= 1'b1;
            end else if (clr_status) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef DBG_DISPATCH_TIMEOUT_EN
    // Counts edges spent in WAIT; restarts on every fresh capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (capture || (state_nxt != WAIT)) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (set_to) begin
                timeout <= 1'b1;
            end else if (clr_status) begin
                timeout <= 1'b0;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign cmd_pending = (state == WAIT);

endmodule

// File: tb/tb_debug_cmd_dispatch.sv
module tb_debug_cmd_dispatch;

    localparam int DATA_W  = 38;
    localparam int IR_W    = 2;
    localparam int NUM_CH  = 4;
    localparam int TIMEOUT = 8;
`ifdef DBG_DISPATCH_TIMEOUT_EN
    localparam int MAX_D   = 3;
`else
    localparam int MAX_D   = 12;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic [DATA_W-1:0]  sr;
    logic [IR_W-1:0]    ir_in;
    logic               udr_tgl;
    logic               uir_tgl;
    logic [NUM_CH-1:0]  ch_ready;
    logic               clr_status;
    logic [DATA_W-1:0]  jdo;
    logic [NUM_CH-1:0]  take_action;
    logic [NUM_CH-1:0]  take_no_action;
    logic               cmd_pending;
    logic               overrun;
    logic               timeout;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    // Reference model of the outstanding command (transaction level).
    logic [DATA_W-1:0]  exp_word;
    int                 exp_ch;

    debug_cmd_dispatch #(
        .DATA_W  (DATA_W),
        .IR_W    (IR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sr             (sr),
        .ir_in          (ir_in),
        .udr_tgl        (udr_tgl),
        .uir_tgl        (uir_tgl),
        .ch_ready       (ch_ready),
        .clr_status     (clr_status),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .cmd_pending    (cmd_pending),
        .overrun        (overrun),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes must be one-hot-or-zero and never both kinds at once.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("strobe_excl",
                64'(((take_action & take_no_action) == '0) &&
                    $onehot0(take_action | take_no_action)), 64'd1);
        end
    end

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[DATA_W-1:0];
    endfunction

    function automatic logic [NUM_CH-1:0] bit_of(input int c);
        return NUM_CH'(1) << c;
    endfunction

    // Issue a command and check it is captured three edges later.
    task automatic send(input logic [DATA_W-1:0] w, input int c);
        ch_ready = NUM_CH'($urandom) & ~bit_of(c);
        sr       = w;
        ir_in    = IR_W'(c);
        udr_tgl  = ~udr_tgl;
        exp_word = w;
        exp_ch   = c;
        tick(); tick();
        chk("pre_capture_pending", 64'(cmd_pending), 64'd0);
        tick();
        chk("capture_jdo", 64'(jdo), 64'(w));
        chk("capture_pending", 64'(cmd_pending), 64'd1);
    endtask

    // Keep the channel busy d cycles, then let it accept and check the strobe.
    task automatic dispatch_after(input int d);
        logic [NUM_CH-1:0] ea;
        logic [NUM_CH-1:0] en;
        ch_ready = ch_ready & ~bit_of(exp_ch);
        for (int i = 0; i < d; i++) begin
            chk("wait_pending", 64'(cmd_pending), 64'd1);
            chk("wait_no_strobe", 64'(take_action | take_no_action), 64'd0);
            chk("wait_jdo", 64'(jdo), 64'(exp_word));
            tick();
        end
        ch_ready = ch_ready | bit_of(exp_ch);
        tick();
        ea = exp_word[DATA_W-1] ? bit_of(exp_ch) : '0;
        en = exp_word[DATA_W-1] ? '0 : bit_of(exp_ch);
        chk("take_action", 64'(take_action), 64'(ea));
        chk("take_no_action", 64'(take_no_action), 64'(en));
        chk("done_pending", 64'(cmd_pending), 64'd0);
        tick();
        chk("strobe_one_cycle", 64'(take_action | take_no_action), 64'd0);
    endtask

    task automatic scn_overrun();
        logic [DATA_W-1:0] w1;
        w1 = rnd_word();
        send(w1, int'($urandom_range(0, NUM_CH-1)));
        sr      = rnd_word();
        ir_in   = IR_W'($urandom);
        udr_tgl = ~udr_tgl;
        tick(); tick(); tick();
        chk("overrun_set", 64'(overrun), 64'd1);
        chk("overrun_jdo_hold", 64'(jdo), 64'(w1));
        chk("overrun_pending", 64'(cmd_pending), 64'd1);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("overrun_clr", 64'(overrun), 64'd0);
        dispatch_after(int'($urandom_range(0, 2)));
    endtask

    task automatic scn_abort_capture();
        logic [DATA_W-1:0] w2;
        int c2;
        send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
        w2 = rnd_word();
        c2 = int'($urandom_range(0, NUM_CH-1));
        ch_ready = '0;
        sr       = w2;
        ir_in    = IR_W'(c2);
        udr_tgl  = ~udr_tgl;
        uir_tgl  = ~uir_tgl;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abortcap_no_strobe", 64'(take_action | take_no_action), 64'd0);
        end
        chk("abortcap_jdo", 64'(jdo), 64'(w2));
        chk("abortcap_pending", 64'(cmd_pending), 64'd1);
        chk("abortcap_no_ovr", 64'(overrun), 64'd0);
        exp_word = w2;
        exp_ch   = c2;
        dispatch_after(int'($urandom_range(0, MAX_D)));
    endtask

    task automatic scn_abort();
        send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
        uir_tgl = ~uir_tgl;
        tick(); tick(); tick();
        chk("abort_pending", 64'(cmd_pending), 64'd0);
        chk("abort_no_ovr", 64'(overrun), 64'd0);
        ch_ready = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_strobe", 64'(take_action | take_no_action), 64'd0);
        end
    endtask

    task automatic scn_reset_wait();
        if (udr_tgl == 1'b1) begin
            send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
            dispatch_after(0);
        end
        send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
        reset_n = 1'b0;
        tick();
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_pending", 64'(cmd_pending), 64'd0);
        chk("rst_strobes", 64'({take_action, take_no_action}), 64'd0);
        chk("rst_flags", 64'({overrun, timeout}), 64'd0);
        reset_n  = 1'b1;
        ch_ready = '1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rst_no_event", 64'({cmd_pending, take_action, take_no_action}), 64'd0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        sr         = '0;
        ir_in      = '0;
        udr_tgl    = 1'b0;
        uir_tgl    = 1'b0;
        ch_ready   = '0;
        clr_status = 1'b0;
        exp_word   = '0;
        exp_ch     = 0;
        tick(); tick();
        chk("reset_jdo", 64'(jdo), 64'd0);
        chk("reset_outs", 64'({take_action, take_no_action, cmd_pending, overrun, timeout}), 64'd0);
        reset_n = 1'b1;
        mon_on  = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Action on channel 2, immediately ready.
        send(38'h20000000AB, 2);
        ch_ready = '1;
        dispatch_after(0);
        // No-action on channel 1 after a busy period.
        send(38'h0012345678, 1);
`ifdef DBG_DISPATCH_TIMEOUT_EN
        dispatch_after(6);
`else
        dispatch_after(10);
`endif
        scn_overrun();
        scn_abort_capture();
        scn_abort();
        scn_reset_wait();
        for (int i = 0; i < 5; i++) tick();

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
                    dispatch_after(int'($urandom_range(0, MAX_D)));
                end
                1: scn_overrun();
                2: scn_abort_capture();
                3: scn_abort();
                default: scn_reset_wait();
            endcase
            chk("no_timeout_flag", 64'(timeout), 64'd0);
        end

`ifdef DBG_DISPATCH_TIMEOUT_EN
        send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
        ch_ready = '0;
        for (int i = 0; i < TIMEOUT; i++) begin
            chk("to_pending", 64'(cmd_pending), 64'd1);
            tick();
        end
        chk("to_flag", 64'(timeout), 64'd1);
        chk("to_pending_clear", 64'(cmd_pending), 64'd0);
        chk("to_no_strobe", 64'(take_action | take_no_action), 64'd0);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("to_clr", 64'(timeout), 64'd0);
`else
        send(rnd_word(), int'($urandom_range(0, NUM_CH-1)));
        ch_ready = '0;
        for (int i = 0; i < 2 * TIMEOUT; i++) tick();
        chk("unbounded_pending", 64'(cmd_pending), 64'd1);
        chk("timeout_tied", 64'(timeout), 64'd0);
        dispatch_after(0);
`endif

        mon_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_cmd_dispatch.md
DEBUG_CMD_DISPATCH -- requirements
Module: debug_cmd_dispatch

Interface
REQ-001 The block SHALL have parameter DATA_W, default 38, giving the JTAG data-register width.
REQ-002 The block SHALL have parameter IR_W, default 2, giving the instruction width; NUM_CH = 2**IR_W is derived.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the pending-command limit in clk cycles (used only with the timeout feature).
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock; one clock; reset is synchronous and active-low.
REQ-005 The block SHALL have port reset_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port sr, input, DATA_W bits: the shift-register snapshot, stable while udr_tgl settles.
REQ-007 The block SHALL have port ir_in, input, IR_W bits: the instruction, stable with sr.
REQ-008 The block SHALL have port udr_tgl, input, 1 bit: asynchronous toggle; each change means update-DR.
REQ-009 The block SHALL have port uir_tgl, input, 1 bit: asynchronous toggle; each change means update-IR.
REQ-010 The block SHALL have port ch_ready, input, NUM_CH bits: per-channel ready to accept a strobe.
REQ-011 The block SHALL have port clr_status, input, 1 bit: clears the sticky flags.
REQ-012 The block SHALL have port jdo, output, DATA_W bits: the captured command word.
REQ-013 The block SHALL have port take_action, output, NUM_CH bits: one-hot single-cycle action strobe.
REQ-014 The block SHALL have port take_no_action, output, NUM_CH bits: one-hot single-cycle no-action strobe.
REQ-015 The block SHALL have port cmd_pending, output, 1 bit: high while in state WAIT.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag; an update-DR was dropped.
REQ-017 The block SHALL have port timeout, output, 1 bit: sticky flag; a pending command was abandoned (tied 0 when the feature is compiled out).

Function
REQ-018 Each toggle input SHALL pass through a two-flop synchroniser plus an edge-detect flop; an event is a difference between the last two stages.
REQ-019 The FSM SHALL have states IDLE and WAIT only.
REQ-020 In IDLE, a udr event SHALL capture jdo<=sr and ch<=ir_in and move to WAIT, 3 clk edges after the edge that first samples the new toggle level.
REQ-021 In WAIT with ch_ready[ch]=1, the next cycle SHALL assert exactly one bit ch of take_action if jdo[DATA_W-1]=1, otherwise of take_no_action, for one cycle, and return to IDLE.
REQ-022 In WAIT with ch_ready[ch]=0, the block SHALL hold state with no strobe and jdo unchanged.
REQ-023 A udr event in WAIT SHALL be dropped, set overrun, and leave jdo unchanged.
REQ-024 A uir event in WAIT SHALL abort to IDLE with no strobe and no flag.
REQ-025 Simultaneous uir and udr events SHALL be handled as an abort followed by capture of the new command (state WAIT, new jdo).
REQ-026 At most one strobe bit SHALL be high per cycle; take_action and take_no_action SHALL never be high together.
REQ-027 clr_status SHALL clear overrun and timeout; a set condition in the same cycle SHALL win.

Reset
REQ-028 While reset_n=0 at a clk edge, the FSM SHALL go to IDLE and jdo, take_action, take_no_action, cmd_pending, overrun, timeout and all synchroniser/edge flops SHALL be 0.
REQ-029 A reset in WAIT SHALL discard the command without a strobe.
REQ-030 The first clk edge after reset SHALL NOT generate an event if a toggle input is already 1; the edge flop is reloaded from the synchroniser before events are enabled.

Configuration
REQ-031 With DBG_DISPATCH_TIMEOUT_EN defined, a counter of width clog2(TIMEOUT+1) SHALL count cycles in WAIT; on reaching TIMEOUT the FSM SHALL return to IDLE without a strobe and set timeout.
REQ-032 Without DBG_DISPATCH_TIMEOUT_EN, WAIT SHALL be unbounded, no counter SHALL exist, and timeout SHALL be 0.

Structure
REQ-033 Package dbg_dispatch_pkg SHALL hold the state enum (IDLE, WAIT) and the default constants for DATA_W, IR_W and TIMEOUT.
REQ-034 Sub-module dbg_toggle_sync SHALL implement the synchroniser, edge detection and the post-reset reload, and be instantiated twice (udr, uir).

Verification
REQ-035 Scenario: ch_ready=all 1, ir_in=2, sr[37]=1, sr=0x2_0000_00AB, toggle udr -> jdo=0x2_0000_00AB 3 edges later and take_action=4'b0100 for exactly 1 cycle.
REQ-036 Scenario: ir_in=1, sr[37]=0, ch_ready[1]=0 for 10 cycles then 1 -> cmd_pending high 10 cycles, then take_no_action=4'b0010 for one cycle.
REQ-037 Scenario: second udr toggle while WAIT -> overrun=1, jdo holds the first word; clr_status clears it.
REQ-038 Scenario: uir and udr toggle on the same edge while WAIT -> no strobe for the old command, jdo takes the new sr, state WAIT.
REQ-039 Scenario: with DBG_DISPATCH_TIMEOUT_EN and TIMEOUT=8, ch_ready=0 -> cmd_pending for 8 cycles, then timeout=1 and no strobe.
REQ-040 Scenario: reset_n=0 during WAIT with udr_tgl=1 held -> all outputs 0 and no spurious event after release.
